light_countdown_disp: RTL and testbench
=======================================

LIGHT_COUNTDOWN_DISP -- requirements
Module: light_countdown_disp

Interface
REQ-001 The module SHALL have parameter RED_SEC, default 2, giving the red-phase display start value in whole seconds (legal range 0-99).
REQ-002 The module SHALL have parameter YEL_SEC, default 3, giving the yellow-phase start value in seconds (legal range 0-99).
REQ-003 The module SHALL have parameter GRN_SEC, default 1, giving the green-phase start value in seconds (legal range 0-99).
REQ-004 The module SHALL have parameter SCAN_DIV, default 50000, giving the number of clk cycles per digit-scan slot (minimum 2).
REQ-005 The module SHALL have the port clk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 The module SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have the port tick, input, 1 bit: a one-clk-wide pulse every 0.1 s.
REQ-008 The module SHALL have the ports r, y and g, inputs, 1 bit each: the traffic-light lamp states, synchronous to clk.
REQ-009 The module SHALL have the port seg, output, 7 bits: active-high segments, with seg[0]=a through seg[6]=g.
REQ-010 The module SHALL have the port an, output, 2 bits: active-low digit enables, with an[1]=tens and an[0]=units.
REQ-011 The module SHALL have the port sec_bcd, output, 8 bits: remaining seconds as BCD, with [7:4]=tens and [3:0]=units.
REQ-012 The module SHALL have the port err, output, 1 bit: high while {r,y,g} is not one-hot.

Function
REQ-013 The block SHALL register {r,y,g} into prev each clk.
REQ-014 A phase entry SHALL occur in any cycle where {r,y,g} is one-hot and differs from prev.
REQ-015 On phase entry, sec_bcd SHALL load the BCD value of RED_SEC, YEL_SEC or GRN_SEC, matching the lamp that is lit, and the tenths counter SHALL load 9, both at the next clk edge.
REQ-016 Outside a phase entry, on each tick with err low, the tenths counter SHALL decrement when it is non-zero; when it is 0, it SHALL reload 9 and sec_bcd SHALL decrement by 1 as BCD (borrow units 0 to 9 with tens minus 1).
REQ-017 sec_bcd SHALL saturate at 8'h00, so that a tick at 00 with tenths 0 leaves it at 00 with tenths reloaded to 9.
REQ-018 If a phase entry and a tick occur in the same cycle, the load SHALL win and the tick SHALL be discarded.
REQ-019 When {r,y,g} is not one-hot, err SHALL be asserted at the next clk edge, and sec_bcd and tenths SHALL hold.
REQ-020 The first one-hot value after a non-one-hot value SHALL count as a phase entry, even when it equals the lamp lit before the error.
REQ-021 The scan counter SHALL count 0 to SCAN_DIV-1 and wrap; on each wrap, the digit select SHALL toggle.
REQ-022 Digit select 0 SHALL drive an=2'b10 with the units digit; digit select 1 SHALL drive an=2'b01 with the tens digit.
REQ-023 The decoder SHALL map digits 0-9 to standard 7-segment patterns (0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, ... 9=7'h6F).
REQ-024 A tens digit of 0 SHALL be blanked (seg=7'h00) while err is low.
REQ-025 While err is high, both digits SHALL show '-' (seg=7'h40).
REQ-026 seg and an SHALL be registered outputs, changing only on clk edges.
REQ-027 sec_bcd SHALL never hold a non-BCD nibble.

Reset
REQ-028 While rst_n is low, regardless of clk, the block SHALL drive: prev=3'b000, sec_bcd=8'h00, tenths=0, err=0, scan counter=0, digit select=0, an=2'b11 (both digits off), seg=7'h00.
REQ-029 After rst_n deasserts, the first one-hot {r,y,g} SHALL be a phase entry, because prev=000.
REQ-030 rst_n asserted mid-countdown SHALL abort the countdown immediately, with no completion of the current second.

Verification
REQ-031 The bench SHALL cover this case: reset, then r=1 held with default parameters -> sec_bcd=8'h02 one cycle later; 8'h01 after the 10th tick; 8'h00 after the 20th tick; still 8'h00 after the 30th tick.
REQ-032 The bench SHALL cover this case: RED_SEC=10, r held -> sec_bcd goes 8'h10 to 8'h09 on the 10th tick (BCD borrow), and the tens digit is blanked afterwards.
REQ-033 The bench SHALL cover this case: r to y switch in the same cycle as a tick, with sec_bcd=8'h01 and tenths=0 -> sec_bcd=8'h03 and tenths=9 next cycle (the tick is dropped).
REQ-034 The bench SHALL cover this case: {r,y,g}=3'b110 for 5 cycles with ticks -> err=1, seg=7'h40 on both digits, sec_bcd unchanged; then r only -> err=0, sec_bcd reloads to 8'h02.
REQ-035 The bench SHALL cover this case: SCAN_DIV=4, g held -> an alternates 2'b10 and 2'b01 every 4 clk cycles, and seg=7'h06 on the units digit and 7'h00 on the tens digit.
REQ-036 The bench SHALL cover this case: rst_n pulled low asynchronously between clk edges mid-countdown -> all outputs take their REQ-028 values before the next clk edge.

Source files
------------

// File: rtl/light_countdown_disp.sv
// Traffic-light countdown display.
// Tracks which lamp is lit, loads that phase's start value in whole seconds
// and counts it down in 0.1 s ticks as two BCD digits. The digits are
// multiplexed onto one 7-segment bus. A lamp pattern that is not one-hot
// raises err, freezes the count and shows "--".
module light_countdown_disp #(
  parameter int RED_SEC  = 2,
  parameter int YEL_SEC  = 3,
  parameter int GRN_SEC  = 1,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       r,
  input  logic       y,
  input  logic       g,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [7:0] sec_bcd,
  output logic       err
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_MAX = CW'(SCAN_DIV - 1);

  localparam logic [7:0] RED_BCD = {4'(RED_SEC / 10), 4'(RED_SEC % 10)};
  localparam logic [7:0] YEL_BCD = {4'(YEL_SEC / 10), 4'(YEL_SEC % 10)};
  localparam logic [7:0] GRN_BCD = {4'(GRN_SEC / 10), 4'(GRN_SEC % 10)};

  // Standard active-high 7-segment patterns, seg[0]=a .. seg[6]=g.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  logic [2:0]    lamps;
  logic [2:0]    prev;
  logic          one_hot;
  logic          entry;
  logic [3:0]    tenths;
  logic [CW-1:0] scan_cnt;
  logic          digit_sel;

  logic [7:0]    sec_next;
  logic [3:0]    tenths_next;
  logic [CW-1:0] scan_next;
  logic          sel_next;
  logic          err_next;
  logic [3:0]    digit;
  logic [6:0]    seg_next;
  logic [1:0]    an_next;

  assign lamps   = {r, y, g};
  assign one_hot = (lamps == 3'b100) || (lamps == 3'b010) || (lamps == 3'b001);
  // prev holds the last non-one-hot pattern during an error, so the first
  // valid pattern afterwards always differs and re-enters the phase.
  assign entry   = one_hot && (lamps != prev);

  // Countdown: a phase entry reloads, otherwise a tick consumes 0.1 s.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    sec_next    = sec_bcd;
    tenths_next = tenths;
    if (entry) begin
      if (lamps == 3'b100)      sec_next = RED_BCD;
      else if (lamps == 3'b010) sec_next = YEL_BCD;
      else                      sec_next = GRN_BCD;
      tenths_next = 4'd9;
    end else if (one_hot && tick && !err) begin
      if (tenths != 4'd0) begin
        tenths_next = tenths - 4'd1;
      end else begin
        tenths_next = 4'd9;
        if (sec_bcd[3:0] != 4'd0)      sec_next = {sec_bcd[7:4], sec_bcd[3:0] - 4'd1};
        else if (sec_bcd[7:4] != 4'd0) sec_next = {sec_bcd[7:4] - 4'd1, 4'd9};
      end
    end
  end

  // Scan timing and the next display word, built from next-state values so
  // seg/an stay aligned with sec_bcd and err.
  always_comb begin
    scan_next = (scan_cnt == SCAN_MAX) ? '0 : scan_cnt + 1'b1;
    sel_next  = digit_sel ^ (scan_cnt == SCAN_MAX);
    err_next  = !one_hot;
    digit     = sel_next ? sec_next[7:4] : sec_next[3:0];
    an_next   = sel_next ? 2'b01 : 2'b10;
    if (err_next)                              seg_next = 7'h40;
    else if (sel_next && sec_next[7:4] == 4'd0) seg_next = 7'h00;
    else                                       seg_next = seg_of(digit);
  end

  // State and registered outputs; reset blanks the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments here so every register samples the
    // values from before this edge, independent of statement order.
    if (!rst_n) begin
      prev      <= 3'b000;
      sec_bcd   <= 8'h00;
      tenths    <= 4'd0;
      err       <= 1'b0;
      scan_cnt  <= '0;
      digit_sel <= 1'b0;
      an        <= 2'b11;
      seg       <= 7'h00;
    end else begin
      prev      <= lamps;
      sec_bcd   <= sec_next;
      tenths    <= tenths_next;
      err       <= err_next;
      scan_cnt  <= scan_next;
      digit_sel <= sel_next;
      an        <= an_next;
      seg       <= seg_next;
    end
  end

endmodule

// File: tb/tb_light_countdown_disp.sv
// Bench for light_countdown_disp. Two instances share stimulus: one with
// default parameters, one with RED_SEC=10 and SCAN_DIV=4. The reference
// model keeps the remaining time as a single integer count of tenths.
module tb_light_countdown_disp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       r = 1'b0, y = 1'b0, g = 1'b0;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic [7:0] sec_a, sec_b;
  logic       err_a, err_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  light_countdown_disp dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .r(r), .y(y), .g(g),
    .seg(seg_a), .an(an_a), .sec_bcd(sec_a), .err(err_a)
  );

  light_countdown_disp #(.RED_SEC(10), .SCAN_DIV(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .r(r), .y(y), .g(g),
    .seg(seg_b), .an(an_b), .sec_bcd(sec_b), .err(err_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int red_of(input int i);  return (i == 0) ? 2 : 10;     endfunction
  function automatic int scan_of(input int i); return (i == 0) ? 50000 : 4;  endfunction

  function automatic bit is_one_hot(input logic [2:0] l);
    return (l == 3'b100) || (l == 3'b010) || (l == 3'b001);
  endfunction

  function automatic int start_of(input int i, input logic [2:0] l);
    if (l == 3'b100) return red_of(i);
    if (l == 3'b010) return 3;
    return 1;
  endfunction

  // Remaining time in tenths; at zero a tick wraps to 9 (seconds stay 0).
  function automatic int next_v(input int i, input int v, input logic [2:0] l,
                                input logic [2:0] p, input logic t);
    if (!is_one_hot(l)) return v;
    if (l != p)         return start_of(i, l) * 10 + 9;
    if (!t)             return v;
    return (v == 0) ? 9 : v - 1;
  endfunction

  int         m_v[2];
  logic [2:0] m_prev;
  logic       m_err;
  int         m_n;   // clock edges since reset

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev <= 3'b000;
      m_err  <= 1'b0;
      m_n    <= 0;
      for (int i = 0; i < 2; i++) m_v[i] <= 0;
    end else begin
      for (int i = 0; i < 2; i++) m_v[i] <= next_v(i, m_v[i], {r, y, g}, m_prev, tick);
      m_prev <= {r, y, g};
      m_err  <= !is_one_hot({r, y, g});
      m_n    <= m_n + 1;
    end
  end

  function automatic logic [6:0] seg_tab(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_sec(input int i);
    int s;
    s = m_v[i] / 10;
    return {4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [1:0] exp_an(input int i);
    if (m_n == 0) return 2'b11;
    return (((m_n / scan_of(i)) % 2) == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [6:0] exp_seg(input int i);
    int s;
    if (m_n == 0) return 7'h00;
    if (m_err)    return 7'h40;
    s = m_v[i] / 10;
    if (((m_n / scan_of(i)) % 2) == 1) return (s / 10 == 0) ? 7'h00 : seg_tab(s / 10);
    return seg_tab(s % 10);
  endfunction

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_sec", 32'(sec_a), 32'(exp_sec(0)));
      check("a_err", 32'(err_a), 32'(m_err));
      check("a_an",  32'(an_a),  32'(exp_an(0)));
      check("a_seg", 32'(seg_a), 32'(exp_seg(0)));
      check("b_sec", 32'(sec_b), 32'(exp_sec(1)));
      check("b_err", 32'(err_b), 32'(m_err));
      check("b_an",  32'(an_b),  32'(exp_an(1)));
      check("b_seg", 32'(seg_b), 32'(exp_seg(1)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [2:0] l, input logic t);
    {r, y, g} = l;
    tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {r, y, g} = 3'b000;
    tick = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_sec", 32'(sec_a), 32'h00);
    check("rst_an",  32'(an_a),  32'h3);
    check("rst_seg", 32'(seg_a), 32'h00);
    check("rst_err", 32'(err_a), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int toggles;
    logic [1:0] last_an;
    logic [2:0] cur;

    // Red countdown to saturation; RED_SEC=10 instance borrows 10 -> 09.
    do_reset();
    drive(3'b100, 1'b0);
    check("a_load_red", 32'(sec_a), 32'h02);
    check("b_load_red", 32'(sec_b), 32'h10);
    for (int k = 1; k <= 30; k++) begin
      drive(3'b100, 1'b1);
      if (k == 10) begin
        check("a_tick10", 32'(sec_a), 32'h01);
        check("b_tick10", 32'(sec_b), 32'h09);
      end
      if (k == 20) begin
        check("a_tick20", 32'(sec_a), 32'h00);
        check("b_tick20", 32'(sec_b), 32'h08);
      end
      if (k == 30) begin
        check("a_tick30", 32'(sec_a), 32'h00);
        check("b_tick30", 32'(sec_b), 32'h07);
      end
    end
    for (int w = 0; w < 8 && an_b != 2'b01; w++) drive(3'b100, 1'b0);
    check("b_tens_an", 32'(an_b), 32'h1);
    check("b_tens_blank", 32'(seg_b), 32'h00);

    // Red -> yellow in the same cycle as a tick at 1.0 s remaining.
    do_reset();
    drive(3'b100, 1'b0);
    repeat (19) drive(3'b100, 1'b1);
    check("a_at_1s", 32'(sec_a), 32'h01);
    drive(3'b010, 1'b1);
    check("a_load_yel", 32'(sec_a), 32'h03);
    check("b_load_yel", 32'(sec_b), 32'h03);
    repeat (9) drive(3'b010, 1'b1);
    check("a_yel_9t", 32'(sec_a), 32'h03);
    drive(3'b010, 1'b1);
    check("a_yel_10t", 32'(sec_a), 32'h02);

    // Two lamps lit: err, dashes, count frozen; then the same lamp re-enters.
    drive(3'b100, 1'b0);
    repeat (3) drive(3'b100, 1'b1);
    repeat (5) begin
      drive(3'b110, 1'b1);
      check("err_flag", 32'(err_a), 32'h1);
      check("err_seg_a", 32'(seg_a), 32'h40);
      check("err_seg_b", 32'(seg_b), 32'h40);
      check("err_hold_a", 32'(sec_a), 32'h02);
      check("err_hold_b", 32'(sec_b), 32'h10);
    end
    drive(3'b100, 1'b0);
    check("err_clear", 32'(err_a), 32'h0);
    check("err_reload", 32'(sec_a), 32'h02);

    // Green held: scan alternates every 4 cycles on the SCAN_DIV=4 instance.
    drive(3'b001, 1'b0);
    toggles = 0;
    last_an = an_b;
    repeat (16) begin
      drive(3'b001, 1'b0);
      if (an_b != last_an) toggles++;
      last_an = an_b;
      if (an_b == 2'b10) check("grn_units", 32'(seg_b), 32'h06);
      else               check("grn_tens",  32'(seg_b), 32'h00);
    end
    check("scan_toggles", 32'(toggles), 32'd4);

    // Asynchronous reset between edges mid-countdown.
    drive(3'b100, 1'b0);
    repeat (7) drive(3'b100, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_sec_a", 32'(sec_a), 32'h00);
    check("async_an_a",  32'(an_a),  32'h3);
    check("async_seg_a", 32'(seg_a), 32'h00);
    check("async_err_a", 32'(err_a), 32'h0);
    check("async_sec_b", 32'(sec_b), 32'h00);
    check("async_an_b",  32'(an_b),  32'h3);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomised phases, ticks and invalid patterns against the model.
    cur = 3'b100;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 3))
          0:       cur = 3'b100;
          1:       cur = 3'b010;
          2:       cur = 3'b001;
          default: cur = 3'($urandom_range(0, 7));
        endcase
      end
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      drive(cur, $urandom_range(0, 1) == 1);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
